// File: rtl/packed_array_assembler_pkg.sv
// Shared types and constants for the packed array assembler: FSM state encoding,
// default frame geometry and the bit positions inside m_err.
package packed_array_assembler_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int DEF_EW   = 5;

    localparam int ERR_LEN = 0;
    localparam int ERR_XZ  = 1;

endpackage

// File: rtl/packed_array_assembler_xz_detect.sv
// Flags an element carrying x or z bits; only meaningful in 4-state simulation,
// a 2-state or synthesised netlist sees a constant 0.
module xz_detect #(
    parameter int EW = 5
) (
    input  logic [EW-1:0] data,
    output logic          flag
);

    assign flag = $isunknown(data);

endmodule

// File: rtl/packed_array_assembler.sv
// Collects a stream of EW-bit element beats into one ROWS x COLS packed frame and
// hands the frame over with a valid/ready handshake, flagging short/long frames.
module packed_array_assembler
    import packed_array_assembler_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int EW   = DEF_EW
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [0:EW-1]                       s_data,
    input  logic                                s_last,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [1:ROWS][COLS-1:0][0:EW-1]     m_data,
    output logic [1:0]                          m_err,
    output logic [7:0]                          frame_cnt,
    output logic [7:0]                          err_cnt
);

    localparam int         TOTAL    = ROWS * COLS;
    localparam logic [5:0] LAST_IDX = 6'(TOTAL - 1);

    state_t                            state_r;
    logic [5:0]                        cnt_r;
    logic [1:ROWS][COLS-1:0][0:EW-1]   m_data_r;
    logic [1:0]                        m_err_r;
    logic                              m_valid_r;
    logic                              s_ready_r;
    logic [7:0]                        frame_cnt_r;
    logic [7:0]                        err_cnt_r;
    logic                              accept_s;
    logic                              xz_s;

    assign accept_s  = s_valid && s_ready_r;
    assign s_ready   = s_ready_r;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign m_err     = m_err_r;
    assign frame_cnt = frame_cnt_r;
    assign err_cnt   = err_cnt_r;

    xz_detect #(
        .EW (EW)
    ) u_xz_detect (
        .data (s_data),
        .flag (xz_s)
    );

    // Frame FSM, element storage, error flags and delivery counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            cnt_r       <= 6'd0;
            m_data_r    <= '0;
            m_err_r     <= 2'b00;
            m_valid_r   <= 1'b0;
            s_ready_r   <= 1'b1;
            frame_cnt_r <= 8'd0;
            err_cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        // Element k lands at row 1+k/COLS, column COLS-1-k%COLS. Slots
                        // never written stay zero, since storage is cleared on handover.
                        for (int r = 1; r <= ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                if (cnt_r == 6'((r - 1) * COLS + (COLS - 1 - c))) begin
                                    m_data_r[r][c] <= s_data;
                                end
                            end
                        end
                        if (xz_s) begin
                            m_err_r[ERR_XZ] <= 1'b1;
                        end
                        cnt_r <= cnt_r + 6'd1;
                        if (s_last) begin
                            state_r   <= HOLD;
                            s_ready_r <= 1'b0;
                            m_valid_r <= 1'b1;
                            if (cnt_r != LAST_IDX) begin
                                m_err_r[ERR_LEN] <= 1'b1;
                            end
                        end else if (cnt_r == LAST_IDX) begin
                            state_r          <= DRAIN;
                            m_err_r[ERR_LEN] <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept_s && s_last) begin
                        state_r   <= HOLD;
                        s_ready_r <= 1'b0;
                        m_valid_r <= 1'b1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state_r     <= FILL;
                        s_ready_r   <= 1'b1;
                        m_valid_r   <= 1'b0;
                        cnt_r       <= 6'd0;
                        m_err_r     <= 2'b00;
                        m_data_r    <= '0;
                        frame_cnt_r <= frame_cnt_r + 8'd1;
                        if ((m_err_r != 2'b00) && (err_cnt_r != 8'hFF)) begin
                            err_cnt_r <= err_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r   <= FILL;
                    s_ready_r <= 1'b1;
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packed_array_assembler.sv
// Directed bench for packed_array_assembler: fixed beat sequences with hand-built
// expected frames, checked with immediate assertions.
module tb_packed_array_assembler;

    typedef logic [1:4][3:0][0:4] frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [0:4]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    frame_t      m_data;
    logic [1:0]  m_err;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    frame_t      exp_f;
    frame_t      held_f;
    logic [4:0]  xd;
    logic        xb;

    packed_array_assembler #(
        .ROWS (4),
        .COLS (4),
        .EW   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_err     (m_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [4:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 5'd0;
    endtask

    task automatic consume();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic build_exp(input int n, input int base);
        exp_f = '0;
        for (int k = 0; k < n; k++) begin
            exp_f[1 + k / 4][3 - k % 4] = 5'(base + k);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 5'd0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // Reset state, observed while rst_n is still low.
        #3;
        chk("rst_m_valid", 128'(m_valid), 128'(1'b0));
        chk("rst_m_data", 128'(m_data), 128'(0));
        chk("rst_m_err", 128'(m_err), 128'(2'b00));
        chk("rst_frame_cnt", 128'(frame_cnt), 128'(8'd0));
        chk("rst_err_cnt", 128'(err_cnt), 128'(8'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_s_ready", 128'(s_ready), 128'(1'b1));

        // Clean 16-beat frame with a two-cycle bubble in the middle.
        for (int k = 0; k < 16; k++) begin
            if (k == 8) begin
                repeat (2) @(posedge clk);
                #1;
                chk("bubble_no_valid", 128'(m_valid), 128'(1'b0));
            end
            beat(5'(k), (k == 15));
        end
        build_exp(16, 0);
        chk("clean_m_valid", 128'(m_valid), 128'(1'b1));
        chk("clean_s_ready", 128'(s_ready), 128'(1'b0));
        chk("clean_first_elem", 128'(m_data[1][3]), 128'(5'd0));
        chk("clean_last_elem", 128'(m_data[4][0]), 128'(5'd15));
        chk("clean_frame", 128'(m_data), 128'(exp_f));
        chk("clean_m_err", 128'(m_err), 128'(2'b00));
        consume();
        chk("clean_frame_cnt", 128'(frame_cnt), 128'(8'd1));
        chk("clean_err_cnt", 128'(err_cnt), 128'(8'd0));
        chk("clean_back_fill", 128'(m_valid), 128'(1'b0));
        chk("clean_ready_again", 128'(s_ready), 128'(1'b1));
        chk("clean_data_cleared", 128'(m_data), 128'(0));

        // Short frame: s_last on the fifth beat.
        for (int k = 0; k < 5; k++) begin
            beat(5'(k), (k == 4));
        end
        build_exp(5, 0);
        chk("short_m_valid", 128'(m_valid), 128'(1'b1));
        chk("short_elem", 128'(m_data[2][3]), 128'(5'd4));
        chk("short_frame", 128'(m_data), 128'(exp_f));
        chk("short_m_err", 128'(m_err), 128'(2'b01));
        consume();
        chk("short_err_cnt", 128'(err_cnt), 128'(8'd1));
        chk("short_frame_cnt", 128'(frame_cnt), 128'(8'd2));

        // Long frame: 20 beats, the last four are drained.
        for (int k = 0; k < 20; k++) begin
            beat(5'(k + 1), (k == 19));
            if (k == 15) begin
                chk("long_draining_no_valid", 128'(m_valid), 128'(1'b0));
                chk("long_draining_ready", 128'(s_ready), 128'(1'b1));
            end
        end
        build_exp(16, 1);
        chk("long_m_valid", 128'(m_valid), 128'(1'b1));
        chk("long_frame", 128'(m_data), 128'(exp_f));
        chk("long_m_err", 128'(m_err), 128'(2'b01));
        consume();
        chk("long_frame_cnt", 128'(frame_cnt), 128'(8'd3));
        chk("long_err_cnt", 128'(err_cnt), 128'(8'd2));

        // Unknown bits in the third beat; the flag only exists in 4-state simulators.
        xd = 5'b0x101;
        xb = $isunknown(xd);
        for (int k = 0; k < 16; k++) begin
            beat((k == 2) ? xd : 5'(k), (k == 15));
        end
        build_exp(16, 0);
        exp_f[1][1] = xd;
        chk("xz_elem", 128'(m_data[1][1]), 128'(xd));
        chk("xz_frame", 128'(m_data), 128'(exp_f));
        chk("xz_m_err", 128'(m_err), 128'({xb, 1'b0}));
        consume();
        chk("xz_frame_cnt", 128'(frame_cnt), 128'(8'd4));
        chk("xz_err_cnt", 128'(err_cnt), 128'(8'd2 + 8'(xb)));

        // Back-pressure in HOLD with the source still pushing.
        for (int k = 0; k < 16; k++) begin
            beat(5'(k + 10), (k == 15));
        end
        build_exp(16, 10);
        held_f  = m_data;
        s_valid = 1'b1;
        s_data  = 5'd31;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_s_ready", 128'(s_ready), 128'(1'b0));
        end
        chk("hold_m_valid", 128'(m_valid), 128'(1'b1));
        chk("hold_frame", 128'(m_data), 128'(exp_f));
        chk("hold_stable", 128'(m_data), 128'(held_f));
        consume();
        s_valid = 1'b0;
        s_data  = 5'd0;
        chk("hold_release_valid", 128'(m_valid), 128'(1'b0));
        chk("hold_release_ready", 128'(s_ready), 128'(1'b1));
        chk("hold_nothing_taken", 128'(m_data), 128'(0));
        chk("hold_frame_cnt", 128'(frame_cnt), 128'(8'd5));

        // Reset in the middle of a frame.
        for (int k = 0; k < 8; k++) begin
            beat(5'(k + 3), 1'b0);
        end
        rst_n = 1'b0;
        #2;
        chk("midrst_m_data", 128'(m_data), 128'(0));
        chk("midrst_m_valid", 128'(m_valid), 128'(1'b0));
        chk("midrst_frame_cnt", 128'(frame_cnt), 128'(8'd0));
        chk("midrst_err_cnt", 128'(err_cnt), 128'(8'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            beat(5'(15 - k), (k == 15));
        end
        exp_f = '0;
        for (int k = 0; k < 16; k++) begin
            exp_f[1 + k / 4][3 - k % 4] = 5'(15 - k);
        end
        chk("postrst_m_valid", 128'(m_valid), 128'(1'b1));
        chk("postrst_frame", 128'(m_data), 128'(exp_f));
        chk("postrst_m_err", 128'(m_err), 128'(2'b00));
        consume();
        chk("postrst_frame_cnt", 128'(frame_cnt), 128'(8'd1));
        chk("postrst_err_cnt", 128'(err_cnt), 128'(8'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/packed_array_assembler.md
PACKED_ARRAY_ASSEMBLER -- requirements
Module: packed_array_assembler

Interface
REQ-001 Parameter ROWS, default 4, outer packed dimension, indexed 1..ROWS.
REQ-002 Parameter COLS, default 4, middle packed dimension, indexed COLS-1..0.
REQ-003 Parameter EW, default 5, element width, indexed 0..EW-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_valid  input  1  element beat valid.
REQ-007 s_ready  output  1  element beat accepted when s_valid && s_ready.
REQ-008 s_data  input  [0:EW-1]  one element.
REQ-009 s_last  input  1  final element of frame.
REQ-010 m_valid  output  1  assembled frame valid.
REQ-011 m_ready  input  1  frame consumed when m_valid && m_ready.
REQ-012 m_data  output  [1:ROWS][COLS-1:0][0:EW-1]  assembled frame, ROWS*COLS*EW bits.
REQ-013 m_err  output  2  bit0 length error, bit1 x/z element seen; qualified by m_valid.
REQ-014 frame_cnt  output  8  frames delivered, wraps 255->0.
REQ-015 err_cnt  output  8  frames delivered with m_err!=0, saturates at 255.

Function
REQ-016 The FSM SHALL have states FILL, DRAIN, HOLD; reset state FILL.
REQ-017 Element k (0-based) of a frame SHALL land at m_data[1+k/COLS][COLS-1-(k%COLS)], so the first beat fills the leftmost element.
REQ-018 s_ready SHALL be 1 in FILL and DRAIN, 0 in HOLD.
REQ-019 FILL: on an accepted beat the element SHALL be stored and the 6-bit element counter incremented.
REQ-020 Beat with s_last at k < ROWS*COLS-1 SHALL complete the frame, zero every unfilled element, set m_err[0], go to HOLD.
REQ-021 Beat at k = ROWS*COLS-1 with s_last SHALL complete the frame cleanly, go to HOLD.
REQ-022 Beat at k = ROWS*COLS-1 without s_last SHALL set m_err[0] and go to DRAIN.
REQ-023 DRAIN SHALL accept and discard beats; the beat with s_last SHALL go to HOLD.
REQ-024 Any accepted stored element containing x or z SHALL set m_err[1] (4-state simulation only; constant 0 in synthesis); the element is stored as received.
REQ-025 HOLD: m_valid=1 and m_data/m_err stable until m_ready; on handshake, frame_cnt +1, err_cnt +1 if m_err!=0, counter and m_err cleared, m_data zeroed, return to FILL.
REQ-026 Latency: m_valid SHALL rise the cycle after the completing beat (FILL) or the s_last beat (DRAIN).
REQ-027 m_valid SHALL be 0 in FILL and DRAIN; no new beat accepted in the handshake cycle.
REQ-028 s_valid low SHALL stall with no state change; bubbles between beats allowed.

Reset
REQ-029 On rst_n low, immediately: state FILL, s_ready 1 once released, m_valid 0, m_data 0, m_err 0, counters 0.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial or pending frame without incrementing any counter.

Structure
REQ-031 Shared package SHALL hold the state enum, default ROWS/COLS/EW, and the m_err bit-position constants.
REQ-032 One sub-module, xz_detect (EW-bit input, 1-bit flag), SHALL hold the 4-state check.
REQ-033 Implementation target 120-400 lines; no latches; one always_ff for state and storage.

Verification
REQ-034 16 beats data k=0..15 as 5'(k), s_last on 16th -> m_data[1][3]=0, m_data[4][0]=15, m_err=0, frame_cnt=1.
REQ-035 s_last on beat 5 (k=4) -> m_data[2][3]=4, m_data[2][2..0] and rows 3-4 zero, m_err=01, err_cnt=1.
REQ-036 20 beats, s_last on 20th -> m_err=01, beats 17-20 discarded, one frame delivered.
REQ-037 Beat 3 data 5'b0x101, clean 16 -> m_err=10, m_data[1][1]=5'b0x101.
REQ-038 m_ready held 0 for 10 cycles in HOLD with s_valid=1 -> s_ready=0, m_data stable, nothing accepted; m_ready=1 -> FILL next cycle.
REQ-039 rst_n pulsed after beat 8 -> outputs zero at once; next clean 16-beat frame correct, frame_cnt=1.
